zeroheti_sba_obi_mgr: RTL and testbench

ZEROHETI_SBA_OBI_MGR -- requirements
Module: zeroheti_sba_obi_mgr

---
 rtl/zeroheti_sba_obi_mgr_if.sv | 34 +++
 rtl/zeroheti_sba_obi_mgr.sv | 163 ++++++++++++++++
 tb/tb_zeroheti_sba_obi_mgr.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/zeroheti_sba_obi_mgr_if.sv
// ----------------------------------------------------------------------------
// OBI_BUS
// Bundles the OBI request/response signals shared by a manager and a
// subordinate.
//   Manager     : drives req/addr/we/be/wdata/aid; receives gnt/rvalid/rdata/rid/err
//   Subordinate : the mirror view
// ----------------------------------------------------------------------------
interface OBI_BUS #(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned IdWidth   = 1
);
   logic                     req;
   logic                     gnt;
   logic [AddrWidth-1:0]     addr;
   logic                     we;
   logic [DataWidth/8-1:0]   be;
   logic [DataWidth-1:0]     wdata;
   logic [IdWidth-1:0]       aid;
   logic                     rvalid;
   logic [DataWidth-1:0]     rdata;
   logic [IdWidth-1:0]       rid;
   logic                     err;

   modport Manager (
      output req, addr, we, be, wdata, aid,
      input  gnt, rvalid, rdata, rid, err
   );

   modport Subordinate (
      input  req, addr, we, be, wdata, aid,
      output gnt, rvalid, rdata, rid, err
   );
endinterface

// File: rtl/zeroheti_sba_obi_mgr.sv
// ----------------------------------------------------------------------------
// zeroheti_sba_obi_mgr
// Bridges the debug module's system bus access (SBA) requests onto an OBI
// manager port, one transaction at a time, with an optional response timeout.
//
// Ports
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   sba_req_i .. sba_be_i  : SBA request from the debug module
//   sba_gnt_o              : request accepted (combinational, IDLE only)
//   sba_rvalid_o           : one-cycle response pulse
//   sba_rdata_o            : read data (0 for writes / when not valid)
//   sba_err_o              : OBI error response
//   sba_other_err_o        : unexpected rid, or timeout
//   obi_mgr                : OBI manager port
// ----------------------------------------------------------------------------
module zeroheti_sba_obi_mgr #(
   parameter int unsigned AddrWidth     = 32,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned IdWidth       = 1,
   parameter int unsigned TimeoutCycles = 255
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   sba_req_i,
   input  logic [AddrWidth-1:0]   sba_addr_i,
   input  logic                   sba_we_i,
   input  logic [DataWidth-1:0]   sba_wdata_i,
   input  logic [DataWidth/8-1:0] sba_be_i,
   output logic                   sba_gnt_o,
   output logic                   sba_rvalid_o,
   output logic [DataWidth-1:0]   sba_rdata_o,
   output logic                   sba_err_o,
   output logic                   sba_other_err_o,
   OBI_BUS.Manager                obi_mgr
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ADDR  = 2'd1;
   localparam logic [1:0] RESP  = 2'd2;
   localparam logic [1:0] DRAIN = 2'd3;

   // Keep at least one bit so the counter stays legal when the timeout is off.
   localparam int unsigned CntWidth =
      (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

   logic [1:0]             r_state;
   logic [CntWidth-1:0]    r_cnt;
   logic [AddrWidth-1:0]   r_addr;
   logic                   r_we;
   logic [DataWidth/8-1:0] r_be;
   logic [DataWidth-1:0]   r_wdata;
   // In DRAIN: whether the abandoned request has already been granted.
   logic                   r_granted;
   logic                   r_rvalid;
   logic [DataWidth-1:0]   r_rdata;
   logic                   r_err;
   logic                   r_other_err;

   logic                   w_gnt;
   logic                   w_timeout;

   assign w_gnt = (r_state == IDLE) && sba_req_i;

   generate
      if (TimeoutCycles > 0) begin : g_timeout
         assign w_timeout = (r_cnt == CntWidth'(TimeoutCycles));
      end else begin : g_no_timeout
         assign w_timeout = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_addr      <= '0;
         r_we        <= 1'b0;
         r_be        <= '0;
         r_wdata     <= '0;
         r_granted   <= 1'b0;
         r_rvalid    <= 1'b0;
         r_rdata     <= '0;
         r_err       <= 1'b0;
         r_other_err <= 1'b0;
      end else begin
         // Response outputs are single-cycle pulses and read as 0 otherwise.
         r_rvalid    <= 1'b0;
         r_rdata     <= '0;
         r_err       <= 1'b0;
         r_other_err <= 1'b0;

         if ((TimeoutCycles != 0) && ((r_state == ADDR) || (r_state == RESP))) begin
            r_cnt <= r_cnt + 1'b1;
         end

         case (r_state)
            IDLE: begin
               if (w_gnt) begin
                  r_addr    <= sba_addr_i;
                  r_we      <= sba_we_i;
                  r_be      <= sba_be_i;
                  r_wdata   <= sba_wdata_i;
                  r_cnt     <= '0;
                  r_granted <= 1'b0;
                  r_state   <= ADDR;
               end
            end
            ADDR: begin
               if (w_timeout) begin
                  // Report now, but the request must still stay up until granted.
                  r_rvalid    <= 1'b1;
                  r_other_err <= 1'b1;
                  r_granted   <= obi_mgr.gnt;
                  r_state     <= DRAIN;
               end else if (obi_mgr.gnt) begin
                  r_state <= RESP;
               end
            end
            RESP: begin
               // A real response beats a timeout landing in the same cycle.
               if (obi_mgr.rvalid) begin
                  r_rvalid    <= 1'b1;
                  r_rdata     <= r_we ? '0 : obi_mgr.rdata;
                  r_err       <= obi_mgr.err;
                  r_other_err <= (obi_mgr.rid != '0);
                  r_state     <= IDLE;
               end else if (w_timeout) begin
                  r_rvalid    <= 1'b1;
                  r_other_err <= 1'b1;
                  r_granted   <= 1'b1;
                  r_state     <= DRAIN;
               end
            end
            DRAIN: begin
               // Finish the abandoned transaction silently so the bus stays
               // consistent before the next request is accepted.
               if (!r_granted) begin
                  if (obi_mgr.gnt) begin
                     r_granted <= 1'b1;
                  end
               end else if (obi_mgr.rvalid) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign sba_gnt_o       = w_gnt;
   assign sba_rvalid_o    = r_rvalid;
   assign sba_rdata_o     = r_rdata;
   assign sba_err_o       = r_err;
   assign sba_other_err_o = r_other_err;

   assign obi_mgr.req   = (r_state == ADDR) || ((r_state == DRAIN) && !r_granted);
   assign obi_mgr.addr  = r_addr;
   assign obi_mgr.we    = r_we;
   assign obi_mgr.be    = r_be;
   assign obi_mgr.wdata = r_wdata;
   assign obi_mgr.aid   = '0;

endmodule

// File: tb/tb_zeroheti_sba_obi_mgr.sv
module tb_zeroheti_sba_obi_mgr;

   localparam int TO = 8;

   logic        clk;
   logic        rst_ni;
   logic        sba_req_i;
   logic [31:0] sba_addr_i;
   logic        sba_we_i;
   logic [31:0] sba_wdata_i;
   logic [3:0]  sba_be_i;
   logic        sba_gnt_o;
   logic        sba_rvalid_o;
   logic [31:0] sba_rdata_o;
   logic        sba_err_o;
   logic        sba_other_err_o;

   int checks = 0;
   int errors = 0;
   int txn_no = 0;

   OBI_BUS #(.AddrWidth(32), .DataWidth(32), .IdWidth(1)) obi ();

   zeroheti_sba_obi_mgr #(
      .AddrWidth(32), .DataWidth(32), .IdWidth(1), .TimeoutCycles(TO)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_ni),
      .sba_req_i       (sba_req_i),
      .sba_addr_i      (sba_addr_i),
      .sba_we_i        (sba_we_i),
      .sba_wdata_i     (sba_wdata_i),
      .sba_be_i        (sba_be_i),
      .sba_gnt_o       (sba_gnt_o),
      .sba_rvalid_o    (sba_rvalid_o),
      .sba_rdata_o     (sba_rdata_o),
      .sba_err_o       (sba_err_o),
      .sba_other_err_o (sba_other_err_o),
      .obi_mgr         (obi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_rvalid"}, {31'd0, sba_rvalid_o}, 32'd0);
      chk({tag, "_rdata"}, sba_rdata_o, 32'd0);
      chk({tag, "_err"}, {31'd0, sba_err_o}, 32'd0);
      chk({tag, "_oerr"}, {31'd0, sba_other_err_o}, 32'd0);
      chk({tag, "_req"}, {31'd0, obi.req}, 32'd0);
   endtask

   // Reference view of one transaction, counted in cycles after the SBA grant
   // (cycle 1 = first cycle the OBI request is visible). The subordinate
   // grants in cycle g and responds in cycle g+r. A response that arrives no
   // later than cycle TO+1 is reported in the following cycle; otherwise the
   // timeout is reported in cycle TO+2 and the late response is swallowed.
   // Either way the bridge is idle again in cycle g+r+1.
   task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                          input logic [3:0] be, input int g, input int r,
                          input logic [31:0] rdata, input logic err, input logic rid);
      bit tmo;
      int pulse;
      int last;
      logic [31:0] e_rdata;
      logic e_err;
      logic e_oerr;
      tmo   = (g + r) > (TO + 1);
      pulse = tmo ? TO + 2 : g + r + 1;
      last  = g + r + 1;

      @(negedge clk);
      sba_req_i   = 1'b1;
      sba_addr_i  = addr;
      sba_we_i    = we;
      sba_wdata_i = wdata;
      sba_be_i    = be;
      obi.gnt     = 1'b0;
      obi.rvalid  = 1'b0;
      #1;
      chk("gnt_idle", {31'd0, sba_gnt_o}, 32'd1);
      chk("req_idle", {31'd0, obi.req}, 32'd0);
      chk("rvalid_idle", {31'd0, sba_rvalid_o}, 32'd0);

      for (int c = 1; c <= last; c++) begin
         @(negedge clk);
         sba_req_i   = (c == last) ? 1'b0 : 1'($urandom_range(0, 1));
         sba_addr_i  = $urandom;
         sba_we_i    = 1'($urandom_range(0, 1));
         sba_wdata_i = $urandom;
         sba_be_i    = 4'($urandom_range(0, 15));
         obi.gnt     = (c == g);
         obi.rvalid  = (c == g + r) || ((c < g) && ($urandom_range(0, 1) == 1));
         obi.rdata   = (c == g + r) ? rdata : $urandom;
         obi.err     = (c == g + r) ? err : 1'($urandom_range(0, 1));
         obi.rid     = (c == g + r) ? rid : 1'($urandom_range(0, 1));
         #1;
         if (c < last) chk("gnt_busy", {31'd0, sba_gnt_o}, 32'd0);
         chk("obi_req", {31'd0, obi.req}, {31'd0, (c <= g)});
         if (c <= g) begin
            chk("obi_addr", obi.addr, addr);
            chk("obi_we", {31'd0, obi.we}, {31'd0, we});
            chk("obi_be", {28'd0, obi.be}, {28'd0, be});
            chk("obi_wdata", obi.wdata, wdata);
            chk("obi_aid", {31'd0, obi.aid}, 32'd0);
         end
         e_rdata = 32'd0;
         e_err   = 1'b0;
         e_oerr  = 1'b0;
         if (c == pulse) begin
            if (tmo) begin
               e_oerr = 1'b1;
            end else begin
               e_rdata = we ? 32'd0 : rdata;
               e_err   = err;
               e_oerr  = rid;
            end
         end
         chk("sba_rvalid", {31'd0, sba_rvalid_o}, {31'd0, (c == pulse)});
         chk("sba_rdata", sba_rdata_o, e_rdata);
         chk("sba_err", {31'd0, sba_err_o}, {31'd0, e_err});
         chk("sba_other_err", {31'd0, sba_other_err_o}, {31'd0, e_oerr});
      end
      obi.rvalid = 1'b0;
      txn_no++;
      $display("txn %0d addr=%08h we=%0d g=%0d r=%0d timeout=%0d", txn_no, addr, we, g, r, tmo);
   endtask

   initial begin
      rst_ni      = 1'b0;
      sba_req_i   = 1'b0;
      sba_addr_i  = '0;
      sba_we_i    = 1'b0;
      sba_wdata_i = '0;
      sba_be_i    = '0;
      obi.gnt     = 1'b0;
      obi.rvalid  = 1'b0;
      obi.rdata   = '0;
      obi.rid     = '0;
      obi.err     = 1'b0;

      repeat (3) @(negedge clk);
      #1;
      check_outputs_zero("reset");
      chk("reset_addr", obi.addr, 32'd0);
      chk("reset_wdata", obi.wdata, 32'd0);
      @(negedge clk);
      rst_ni = 1'b1;

      // Basic read.
      run_txn(32'h0000_1000, 1'b0, 32'h0, 4'hF, 2, 3, 32'hDEAD_BEEF, 1'b0, 1'b0);
      // Write with an OBI error response.
      run_txn(32'h0000_2004, 1'b1, 32'h1234_5678, 4'h3, 3, 1, 32'hCAFE_F00D, 1'b1, 1'b0);
      // Granted, response withheld past the limit, late response drained.
      run_txn(32'h0000_3000, 1'b0, 32'h0, 4'hF, 1, TO + 5, 32'h1111_2222, 1'b0, 1'b0);
      // Grant withheld past the limit; request must stay up until granted.
      run_txn(32'h0000_4000, 1'b1, 32'hA5A5_A5A5, 4'hC, TO + 4, 2, 32'h0, 1'b0, 1'b0);
      // Response in the exact timeout cycle wins.
      run_txn(32'h0000_5000, 1'b0, 32'h0, 4'hF, 2, TO - 1, 32'h5555_AAAA, 1'b0, 1'b0);
      // Unexpected rid.
      run_txn(32'h0000_6000, 1'b0, 32'h0, 4'hF, 1, 1, 32'h0BAD_0001, 1'b0, 1'b1);

      // Reset while waiting for the response.
      @(negedge clk);
      sba_req_i  = 1'b1;
      sba_addr_i = 32'h0000_7000;
      sba_we_i   = 1'b0;
      @(negedge clk);
      sba_req_i = 1'b0;
      obi.gnt   = 1'b1;
      @(negedge clk);
      obi.gnt = 1'b0;
      @(negedge clk);
      rst_ni = 1'b0;
      #1;
      check_outputs_zero("rst_mid");
      chk("rst_mid_addr", obi.addr, 32'd0);
      @(negedge clk);
      obi.rvalid = 1'b1;
      obi.rdata  = 32'hFFFF_0000;
      @(negedge clk);
      rst_ni = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         check_outputs_zero("post_rst");
      end
      @(negedge clk);
      obi.rvalid = 1'b0;
      txn_no++;
      $display("txn %0d reset during response wait", txn_no);
      run_txn(32'h0000_8000, 1'b0, 32'h0, 4'hF, 1, 2, 32'h7777_8888, 1'b0, 1'b0);

      // Random traffic; some combinations cross the timeout.
      for (int n = 0; n < 20; n++) begin
         run_txn($urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                 int'($urandom_range(1, 6)), int'($urandom_range(1, 8)), $urandom,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
